pipe_ctrl: RTL
==============

// Module: pipe_ctrl
// PURPOSE
//  Pipeline sequencer for the five-stage core. Generates the stall[5:0] and flush
//  controls consumed by pc_reg, if_id, id_ex, ex_mem and mem_wb, plus new_pc on exceptions.
//  Arbitrates stall requests and sequences exception entry/ERET.
//  When an exception lands during an in-flight instruction fetch, it drains that fetch
//  before fetching resumes. Keeps a stall-cycle performance counter.
// PARAMETERS
//  EXC_VECTOR  32'h0000_0020  new_pc for every exception except ERET
//  WDT_CYCLES  64             max DRAIN cycles before forced exit (>=2)
// PORTS
//  clk                clk  in   1   single clock; all state updates on posedge
//  rst                in   1    synchronous, active-high reset
//  stallreq_from_if   in   1    instruction bus busy
//  stallreq_from_id   in   1    load-use hazard
//  stallreq_from_ex   in   1    multi-cycle ex op (madd/div)
//  stallreq_from_mem  in   1    data bus busy
//  excepttype_i       in   32   exception code from mem stage; 0 = none
//  cp0_epc_i          in   32   EPC for ERET
//  stall              out  6    [0]pc [1]if [2]id [3]ex [4]mem [5]wb; 1 = Stop
//  flush              out  1    clear all pipeline registers this cycle
//  new_pc             out  32   PC target, valid when flush=1
//  in_drain_o         out  1    FSM in DRAIN
//  drain_timeout_o    out  1    1-cycle registered pulse on watchdog expiry
//  stall_cnt_o        out  32   saturating count of cycles with stall[0]=1
// BEHAVIOUR
//  - Reset: FSM=RUN, wdt=0, stall_cnt_o=0, drain_timeout_o=0. While rst=1:
//    stall=0, flush=0, new_pc=0.
//  - stall/flush/new_pc are combinational from inputs and state (0-cycle latency).
//    Stage k stopped with stage k+1 running means a bubble is inserted downstream.
//  - exc_valid = (excepttype_i!=0) && !stallreq_from_mem. excepttype_i is ignored
//    while mem is stalled; the mem stage re-presents it.
//  - RUN, priority high->low:
//    - exc_valid: flush=1, stall=0, new_pc = (excepttype_i==32'h0000_000e) ? cp0_epc_i : EXC_VECTOR.
//      Next state is DRAIN if stallreq_from_if=1, else RUN.
//    - mem req: stall=6'b011111
//    - ex req: stall=6'b001111
//    - id req: stall=6'b000111
//    - if req: stall=6'b000011
//    - otherwise: stall=0
//  - DRAIN: the discarded fetch completes; PC (already loaded with new_pc) and IF are held.
//    - stall=6'b000011, flush=0; wdt increments each cycle.
//    - stallreq_from_if=0 -> RUN next cycle; the returned instruction becomes a bubble in if_id.
//    - wdt==WDT_CYCLES-1 with stallreq_from_if still 1 -> RUN next cycle, drain_timeout_o=1 next cycle.
//    - exc_valid in DRAIN (interrupt): flush=1, stall=0, new_pc recomputed; stay in DRAIN, wdt reset to 0.
//    - stallreq_from_id/ex/mem are ignored in DRAIN (stages hold only bubbles).
//  - wdt is cleared on every entry to DRAIN and in RUN. Width $clog2(WDT_CYCLES).
//  - stall_cnt_o += 1 on every cycle with stall[0]=1 (RUN or DRAIN); holds at 32'hFFFF_FFFF.
//  - Reset mid-DRAIN: immediate return to RUN; no timeout pulse.
//  - in_drain_o = (state==DRAIN), combinational from the state register.
// STRUCTURE
//  - defines.v gets: `StallMem/`StallEx/`StallId/`StallIf/`StallDrain patterns,
//    `EXC_ERET 32'h0000_000e, 1-bit state codes `PC_RUN/`PC_DRAIN.
//  - Single flat module, no sub-modules. Comb block for stall/flush/new_pc/next_state;
//    one clocked block for state, wdt, stall_cnt_o, drain_timeout_o.
// TESTING
//  1. stallreq_from_id=1 and stallreq_from_ex=1 together -> stall=6'b001111.
//     Add stallreq_from_mem=1 -> 6'b011111.
//  2. excepttype_i=32'h8, if idle -> flush=1, new_pc=32'h20, stall=0 same cycle; next cycle RUN, flush=0.
//  3. excepttype_i=32'he, cp0_epc_i=32'h0000_1234 -> new_pc=32'h1234.
//     Repeat with stallreq_from_mem=1 -> flush=0, stall=6'b011111.
//  4. Exception with stallreq_from_if=1 held 3 more cycles -> in_drain_o=1 for 3 cycles with stall=6'b000011;
//     RUN after release; stall_cnt_o advanced by 3.
//  5. DRAIN with stallreq_from_if stuck at 1, WDT_CYCLES=64 -> drain_timeout_o pulses once after 64 DRAIN cycles;
//     FSM returns to RUN. Separately, rst asserted mid-DRAIN -> RUN, all outputs 0.
//  6. Force stall_cnt_o to 32'hFFFF_FFFE, hold stallreq_from_ex=1 for 3 cycles -> saturates at 32'hFFFF_FFFF.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline sequencer: FSM states, stall patterns and the ERET code.
package pipe_ctrl_pkg;

  typedef enum logic {
    PC_RUN   = 1'b0,
    PC_DRAIN = 1'b1
  } pc_state_e;

  // stall bit order: [0]pc [1]if [2]id [3]ex [4]mem [5]wb
  localparam logic [5:0] STALL_NONE  = 6'b000000;
  localparam logic [5:0] STALL_MEM   = 6'b011111;
  localparam logic [5:0] STALL_EX    = 6'b001111;
  localparam logic [5:0] STALL_ID    = 6'b000111;
  localparam logic [5:0] STALL_IF    = 6'b000011;
  localparam logic [5:0] STALL_DRAIN = 6'b000011;

  localparam logic [31:0] EXC_ERET = 32'h0000_000e;

endpackage

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: combinational stall/flush/new_pc arbitration, exception entry with
// drain of an in-flight fetch (watchdog-bounded), and a saturating stall-cycle counter.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0020,
  parameter int          WDT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_from_if,
  input  logic        stallreq_from_id,
  input  logic        stallreq_from_ex,
  input  logic        stallreq_from_mem,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] cp0_epc_i,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        in_drain_o,
  output logic        drain_timeout_o,
  output logic [31:0] stall_cnt_o
);

  localparam int WDT_W = (WDT_CYCLES > 2) ? $clog2(WDT_CYCLES) : 1;
  localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_CYCLES - 1);

  pc_state_e        state, next_state;
  logic [WDT_W-1:0] wdt;
  logic             wdt_run;
  logic             timeout_next;
  logic             exc_valid;
  logic [31:0]      exc_pc;

  // The mem stage re-presents its exception once it is no longer stalled.
  assign exc_valid  = (excepttype_i != 32'd0) && !stallreq_from_mem;
  assign exc_pc     = (excepttype_i == EXC_ERET) ? cp0_epc_i : EXC_VECTOR;
  assign in_drain_o = (state == PC_DRAIN);

  always_comb begin
    stall        = STALL_NONE;
    flush        = 1'b0;
    new_pc       = 32'd0;
    next_state   = state;
    wdt_run      = 1'b0;
    timeout_next = 1'b0;
    if (!rst) begin
      unique case (state)
        PC_RUN: begin
          if (exc_valid) begin
            flush      = 1'b1;
            new_pc     = exc_pc;
            next_state = stallreq_from_if ? PC_DRAIN : PC_RUN;
          end else if (stallreq_from_mem) begin
            stall = STALL_MEM;
          end else if (stallreq_from_ex) begin
            stall = STALL_EX;
          end else if (stallreq_from_id) begin
            stall = STALL_ID;
          end else if (stallreq_from_if) begin
            stall = STALL_IF;
          end
        end
        PC_DRAIN: begin
          // Downstream stages hold only bubbles here, so id/ex/mem requests are moot.
          if (exc_valid) begin
            flush  = 1'b1;
            new_pc = exc_pc;
          end else begin
            stall = STALL_DRAIN;
            if (!stallreq_from_if) begin
              next_state = PC_RUN;
            end else if (wdt == WDT_LAST) begin
              next_state   = PC_RUN;
              timeout_next = 1'b1;
            end else begin
              wdt_run = 1'b1;
            end
          end
        end
        default: next_state = PC_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= PC_RUN;
      wdt             <= '0;
      stall_cnt_o     <= 32'd0;
      drain_timeout_o <= 1'b0;
    end else begin
      state           <= next_state;
      drain_timeout_o <= timeout_next;
      wdt             <= wdt_run ? wdt + 1'b1 : '0;
      if (stall[0] && (stall_cnt_o != 32'hFFFF_FFFF)) begin
        stall_cnt_o <= stall_cnt_o + 32'd1;
      end
    end
  end

endmodule
